// File: rtl/rv_fetch_stage.sv
// rv_fetch_stage: owns the PC, issues word fetches to instruction memory and
// buffers returned instructions (tagged with their PC) for decode.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When defined, a redirect to a
// target with target[1:0] != 0 raises a sticky fetch_fault and halts fetch
// until reset. When undefined, fetch_fault is tied low and target[1:0] is
// cleared as the target is loaded into the PC.
//
// Handshakes: a request transfers on the rising edge where imem_req_valid and
// imem_req_ready are both high; imem_req_valid never depends on
// imem_req_ready. Responses have no backpressure and return in request order.
// An instruction leaves the buffer on the edge where inst_valid && inst_ready.
module rv_fetch_stage #(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_target,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [63:0] inst_pc,
    output logic        fetch_fault
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int SW = CW + 1;
    localparam logic [SW-1:0] DEPTH_C = SW'(FIFO_DEPTH);

    logic [63:0]   pc;
    logic [63:0]   rsp_pc;
    logic [31:0]   buf_inst [FIFO_DEPTH];
    logic [63:0]   buf_pc   [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] outstanding_next;
    logic [CW-1:0] drop_cnt_next;
    logic [63:0]   load_pc;
    logic          halted;
    logic          credit_ok;
    logic          issue;
    logic          rsp_hit;
    logic          push;
    logic          pop;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misaligned;

    assign misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
    assign load_pc    = redirect_target;

    // Sticky fault and halt on a misaligned redirect; only reset clears them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            halted      <= 1'b0;
            fetch_fault <= 1'b0;
        end else if (misaligned) begin
            halted      <= 1'b1;
            fetch_fault <= 1'b1;
        end
    end
`else
    assign load_pc     = redirect_target & ~64'h3;
    assign halted      = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    // Buffered plus in-flight fetches never exceed the buffer size, so every
    // response that is kept always has a free slot.
    assign credit_ok      = ({1'b0, count} + {1'b0, outstanding}) < DEPTH_C;
    assign imem_req_valid = rst_n && credit_ok && !redirect_valid && !halted;
    assign imem_req_addr  = pc;
    assign issue          = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_hit = imem_rsp_valid && (outstanding != '0);
    assign push    = rsp_hit && (drop_cnt == '0) && !redirect_valid && !halted;

    assign inst_valid = (count != '0);
    assign pop        = inst_valid && inst_ready && !redirect_valid;
    assign inst_out   = buf_inst[rd_ptr];
    assign inst_pc    = buf_pc[rd_ptr];

    // In-flight and stale-response counters for the coming edge.
    always_comb begin
        outstanding_next = outstanding;
        if (issue && !rsp_hit) begin
            outstanding_next = outstanding + CW'(1);
        end else if (!issue && rsp_hit) begin
            outstanding_next = outstanding - CW'(1);
        end

        drop_cnt_next = drop_cnt;
        if (redirect_valid) begin
            // Everything still in flight after this edge belongs to the old path.
            drop_cnt_next = outstanding_next;
        end else if (rsp_hit && (drop_cnt != '0)) begin
            drop_cnt_next = drop_cnt - CW'(1);
        end
    end

    // Fetch PC, response PC and counters; redirect overrides sequential advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_next;
            drop_cnt    <= drop_cnt_next;
            if (redirect_valid) begin
                pc     <= load_pc;
                rsp_pc <= load_pc;
            end else begin
                if (issue) begin
                    pc <= pc + 64'd4;
                end
                if (push) begin
                    rsp_pc <= rsp_pc + 64'd4;
                end
            end
        end
    end

    // Instruction buffer storage; pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_inst[wr_ptr] <= imem_rsp_data;
            buf_pc[wr_ptr]   <= rsp_pc;
        end
    end

    // Buffer pointers and occupancy; a redirect or halt empties the buffer.
    always_ff @(posedge clk) begin
        if (!rst_n || redirect_valid || halted) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Stale responses are a subset of in-flight ones, which are bounded by the buffer size.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert ((drop_cnt <= outstanding) && ({1'b0, outstanding} <= DEPTH_C));
        end
    end

endmodule

// File: tb/tb_rv_fetch_stage.sv
// Bench for rv_fetch_stage: a randomized instruction memory plus a
// transaction-level model (request queue, expected decode queue) that
// predicts every handshake and every buffered instruction.
module tb_rv_fetch_stage;

    localparam logic [63:0] RESET_PC = 64'h1000;
    localparam int          DEPTH    = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_target;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_out;
    logic [63:0] inst_pc;
    logic        fetch_fault;

    rv_fetch_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .inst_valid      (inst_valid),
        .inst_ready      (inst_ready),
        .inst_out        (inst_out),
        .inst_pc         (inst_pc),
        .fetch_fault     (fetch_fault)
    );

    // Clock and reset-time input values.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [63:0] addr;
        logic        stale;
        int          due;
    } req_t;

    req_t        mem_q[$];    // accepted requests not yet answered
    logic [63:0] exp_q[$];    // PCs expected in the decode buffer, in order
    logic [63:0] next_req;    // address the next accepted request must carry
    logic        halted_m;
    logic        fault_m;
    int          cyc;
    int          n_checks;
    int          n_pass;

    // Stimulus knobs (percent unless noted).
    int          p_ready;
    int          p_mready;
    int          p_rsp;
    int          p_redir;
    int          p_rst_pm;    // per mille
    int          p_stray;
    int          lat_min;
    int          lat_extra;
    logic        force_redir;
    logic [63:0] force_target;
    logic        force_rst;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [63:0] rand_target();
        logic [63:0] t;
        t = {($urandom_range(3) == 0) ? 32'hFFFF_FFFF : 32'h0, $urandom()};
        t[1:0] = ($urandom_range(9) == 0) ? 2'($urandom_range(3)) : 2'b00;
        return t;
    endfunction

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step();
        logic        rst;
        logic        redir;
        logic [63:0] tgt;
        logic        rsp;
        logic        mready;
        logic        iready;
        logic        exp_req_valid;
        req_t        r;

        @(posedge clk);
        #1;
        cyc++;
        rst    = !(force_rst || ($urandom_range(999) < p_rst_pm));
        redir  = force_redir || ($urandom_range(99) < p_redir);
        tgt    = force_redir ? force_target : rand_target();
        mready = ($urandom_range(99) < p_mready);
        iready = ($urandom_range(99) < p_ready);
        rsp    = 1'b0;
        if (mem_q.size() > 0) begin
            if ((mem_q[0].due <= cyc) && ($urandom_range(99) < p_rsp)) rsp = 1'b1;
        end else if ($urandom_range(99) < p_stray) begin
            rsp = 1'b1;
        end
        rst_n           = rst;
        redirect_valid  = redir;
        redirect_target = tgt;
        imem_req_ready  = mready;
        inst_ready      = iready;
        imem_rsp_valid  = rsp;
        imem_rsp_data   = (mem_q.size() > 0) ? mem_word(mem_q[0].addr) : 32'($urandom());
        force_redir     = 1'b0;
        force_rst       = 1'b0;
        #1;

        exp_req_valid = rst && !redir && !halted_m && ((exp_q.size() + mem_q.size()) < DEPTH);
        check("req_valid", 64'(imem_req_valid), 64'(exp_req_valid));
        if (exp_req_valid) check("req_addr", imem_req_addr, next_req);
        check("inst_valid", 64'(inst_valid), 64'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
            check("inst_pc", inst_pc, exp_q[0]);
            check("inst_out", 64'(inst_out), 64'(mem_word(exp_q[0])));
        end
        check("fetch_fault", 64'(fetch_fault), 64'(fault_m));

        if (!rst) begin
            mem_q.delete();
            exp_q.delete();
            next_req = RESET_PC;
            halted_m = 1'b0;
            fault_m  = 1'b0;
        end else begin
            if ((exp_q.size() != 0) && iready && !redir) void'(exp_q.pop_front());
            if (rsp && (mem_q.size() > 0)) begin
                r = mem_q.pop_front();
                if (!r.stale && !redir && !halted_m) exp_q.push_back(r.addr);
            end
            if (exp_req_valid && mready) begin
                mem_q.push_back('{next_req, 1'b0, cyc + lat_min + int'($urandom_range(lat_extra))});
                next_req = next_req + 64'd4;
            end
            if (redir) begin
                exp_q.delete();
                foreach (mem_q[i]) mem_q[i].stale = 1'b1;
`ifdef FETCH_ALIGN_CHECK_EN
                next_req = tgt;
                if (tgt[1:0] != 2'b00) begin
                    halted_m = 1'b1;
                    fault_m  = 1'b1;
                end
`else
                next_req = {tgt[63:2], 2'b00};
`endif
            end
            if (halted_m) exp_q.delete();
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic redirect_to(input logic [63:0] t);
        force_redir  = 1'b1;
        force_target = t;
        step();
    endtask

    task automatic wait_inflight(input int n);
        for (int i = 0; i < 12; i++) begin
            if (mem_q.size() >= n) break;
            step();
        end
        check("inflight_reached", 64'(mem_q.size() >= n), 64'd1);
    endtask

    // Directed scenarios followed by a long randomized run.
    initial begin
        rst_n = 1'b0; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        redirect_valid = 1'b0; redirect_target = '0; inst_ready = 1'b0;
        next_req = RESET_PC; halted_m = 1'b0; fault_m = 1'b0;
        cyc = 0; n_checks = 0; n_pass = 0;
        p_ready = 100; p_mready = 100; p_rsp = 100; p_redir = 0; p_rst_pm = 0;
        p_stray = 0; lat_min = 1; lat_extra = 0;
        force_redir = 1'b0; force_target = '0; force_rst = 1'b0;

        force_rst = 1'b1; step();
        force_rst = 1'b1; step();
        run(20);

        p_ready = 0; run(12);
        p_ready = 100; run(10);

        lat_min = 3; wait_inflight(2);
        redirect_to(64'h2000); run(15);

        lat_min = 1; run(6);
        redirect_to(64'h3000); run(8);

        lat_min = 3; run(4); wait_inflight(2);
        force_rst = 1'b1; p_stray = 100; step();
        p_stray = 0; run(10);

        lat_min = 1;
        redirect_to(64'h2002); run(10);
        force_rst = 1'b1; step(); run(5);

        redirect_to(64'hFFFF_FFFF_FFFF_FFF8); run(8);

        p_ready = 70; p_mready = 70; p_rsp = 60; lat_min = 1; lat_extra = 3;
        p_redir = 5; p_rst_pm = 5; p_stray = 10;
        run(3000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
